// File: rtl/ref_filter_ctrl_if.sv
// Handshake bundle between the reference smoothing controller, the reference
// selection stage and the intra predictor.
interface ref_filter_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_mode;
  logic [1:0]       cmd_cidx;
  logic             ref_req;
  logic             ref_ack;
  logic             ref_hold;
  logic             filter_flag;
  logic             pred_valid;
  logic             pred_ready;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_cidx, ref_ack, pred_ready, abort,
    output cmd_ready, ref_req, ref_hold, filter_flag, pred_valid, busy, blk_cnt
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_cidx, ref_ack, pred_ready, abort,
    input  cmd_ready, ref_req, ref_hold, filter_flag, pred_valid, busy, blk_cnt
  );
endinterface

// File: rtl/ref_filter_ctrl.sv
// Sequencer for 8x8 intra reference-sample smoothing: command accept, reference
// request, filter latency wait and predictor handshake.
//
// state   | meaning
// S_IDLE  | ready for a block command
// S_REQ   | requesting reference samples, waiting for ref_ack
// S_WAIT  | counting down filter register latency
// S_VALID | filtered samples offered to the predictor
module ref_filter_ctrl #(
  parameter int FILT_LAT = 1,
  parameter int THRES    = 7,
  parameter int CNT_W    = 16
) (
  input logic              CLK1,
  input logic              RST,
  ref_filter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

  localparam logic [2:0] LAT_V   = 3'(FILT_LAT);
  localparam logic [6:0] THRES_V = 7'(THRES);

  state_t           state_q, state_d;
  logic             ref_req_q, ref_req_d;
  logic             ref_hold_q, ref_hold_d;
  logic             flag_q, flag_d;
  logic             pvalid_q, pvalid_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] blk_q, blk_d;

  logic signed [6:0] d26, d10;
  logic [6:0]        a26, a10, dmin;
  logic              flag_calc;

  // Smoothing decision on the raw command fields, captured at acceptance.
  always_comb begin
    d26  = $signed({1'b0, bus.cmd_mode}) - 7'sd26;
    d10  = $signed({1'b0, bus.cmd_mode}) - 7'sd10;
    a26  = d26[6] ? -d26 : d26;
    a10  = d10[6] ? -d10 : d10;
    dmin = (a26 < a10) ? a26 : a10;
    if (bus.cmd_cidx != 2'd0 || bus.cmd_mode == 6'd1 || bus.cmd_mode > 6'd34)
      flag_calc = 1'b0;
    else if (bus.cmd_mode == 6'd0)
      flag_calc = 1'b1;
    else
      flag_calc = dmin > THRES_V;
  end

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ref_req_q  <= 1'b0;
      ref_hold_q <= 1'b0;
      flag_q     <= 1'b0;
      pvalid_q   <= 1'b0;
      cnt_q      <= '0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      ref_req_q  <= ref_req_d;
      ref_hold_q <= ref_hold_d;
      flag_q     <= flag_d;
      pvalid_q   <= pvalid_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_req_d  = ref_req_q;
    ref_hold_d = ref_hold_q;
    flag_d     = flag_q;
    pvalid_d   = pvalid_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    if (bus.abort) begin
      state_d    = S_IDLE;
      ref_req_d  = 1'b0;
      ref_hold_d = 1'b0;
      flag_d     = 1'b0;
      pvalid_d   = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state_d    = S_REQ;
            ref_req_d  = 1'b1;
            // Hold is registered, so raise it now to cover the ref_ack cycle.
            ref_hold_d = 1'b1;
            flag_d     = flag_calc;
          end
        end
        S_REQ: begin
          if (bus.ref_ack) begin
            ref_req_d = 1'b0;
            cnt_d     = LAT_V;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d  = S_VALID;
            pvalid_d = 1'b1;
          end
        end
        S_VALID: begin
          if (bus.pred_ready) begin
            blk_d      = blk_q + CNT_W'(1);
            state_d    = S_IDLE;
            pvalid_d   = 1'b0;
            ref_hold_d = 1'b0;
            flag_d     = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ref_req     = ref_req_q;
  assign bus.ref_hold    = ref_hold_q;
  assign bus.filter_flag = flag_q;
  assign bus.pred_valid  = pvalid_q;
  assign bus.blk_cnt     = blk_q;

endmodule
